// File: rtl/pipe_stage_skid_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_skid_if                                           |
// | Description : Valid/ready stream carrying an opaque payload and a control  |
// |               field between two pipeline stages.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pipe_stage_skid_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 12
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  // Producer side of the stream
  modport master (
    output valid,
    output data,
    output ctrl,
    input  ready
  );

  // Consumer side of the stream
  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pipe_stage_skid                                              |
// | Description : Generic pipeline stage register with valid/ready handshake,  |
// |               2-entry skid buffer, registered upstream ready and flush to  |
// |               a NOP control pattern.                                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pipe_stage_skid #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 12,
  parameter logic [CTRL_W-1:0] NOP_CTRL = {CTRL_W{1'b0}}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  pipe_stage_skid_if.slave        up,
  pipe_stage_skid_if.master       dn,
  output logic [1:0]              occupancy_o
);

  // Encoding equals the number of held entries, so the state drives occupancy
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              ready_q, ready_d;

  logic up_xfer;
  logic dn_xfer;

  // Main entry always holds 0/NOP_CTRL when not valid, so outputs come straight from flops
  assign dn.valid    = (state_q != S_EMPTY);
  assign dn.data     = main_data_q;
  assign dn.ctrl     = main_ctrl_q;
  assign up.ready    = ready_q;
  assign occupancy_o = state_q;

  assign up_xfer = up.valid & ready_q;
  assign dn_xfer = dn.valid & dn.ready;

  // Next-state and entry update; flush overrides everything and empties the stage
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    case (state_q)
      S_EMPTY: begin
        if (up_xfer) begin
          main_data_d = up.data;
          main_ctrl_d = up.ctrl;
          state_d     = S_ONE;
        end
      end
      S_ONE: begin
        if (dn_xfer && up_xfer) begin
          main_data_d = up.data;
          main_ctrl_d = up.ctrl;
        end else if (dn_xfer) begin
          main_data_d = '0;
          main_ctrl_d = NOP_CTRL;
          state_d     = S_EMPTY;
        end else if (up_xfer) begin
          skid_data_d = up.data;
          skid_ctrl_d = up.ctrl;
          state_d     = S_TWO;
        end
      end
      S_TWO: begin
        // Upstream is held off by ready_q=0 here, so only a drain can occur
        if (dn_xfer) begin
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
          skid_data_d = '0;
          skid_ctrl_d = NOP_CTRL;
          state_d     = S_ONE;
        end
      end
      default: begin
        main_data_d = '0;
        main_ctrl_d = NOP_CTRL;
        skid_data_d = '0;
        skid_ctrl_d = NOP_CTRL;
        state_d     = S_EMPTY;
      end
    endcase

    if (flush_i) begin
      main_data_d = '0;
      main_ctrl_d = NOP_CTRL;
      skid_data_d = '0;
      skid_ctrl_d = NOP_CTRL;
      state_d     = S_EMPTY;
    end

    // Registered ready: low exactly while the stage will be full next cycle
    ready_d = (state_d != S_TWO);
  end

  // State and storage registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= NOP_CTRL;
      skid_data_q <= '0;
      skid_ctrl_q <= NOP_CTRL;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      ready_q     <= ready_d;
    end
  end

endmodule
`default_nettype wire
